// File: rtl/wddl_pkg.sv
// wddl_pkg: shared definitions for the dual-rail (WDDL) logic stage.
//   op_sel encodings, FSM state enumeration, precharge counter width.
//   Latency/backpressure: n/a (definitions only).
package wddl_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_PRE  = 2'b00,
    ST_WAIT = 2'b01,
    ST_EVAL = 2'b10
  } state_e;

  // Precharge counter width; holds PRE_CYCLES up to 15.
  localparam int PRE_CNT_W = 4;

endpackage

// File: rtl/wddl_bit_cell.sv
// wddl_bit_cell: one bit of dual-rail AND/OR/XOR/XNOR with codeword check.
//   Latency: combinational. Backpressure: none.
//   Ports: op_sel (operation), a_t/a_f/b_t/b_f (operand rails),
//          o_t/o_f (result rails, 00 when invalid), invalid (non-codeword seen).
module wddl_bit_cell
  import wddl_pkg::*;
(
  input  logic [1:0] op_sel,
  input  logic       a_t,
  input  logic       a_f,
  input  logic       b_t,
  input  logic       b_f,
  output logic       o_t,
  output logic       o_f,
  output logic       invalid
);

  logic t_raw;
  logic f_raw;

  // A rail pair is a codeword only when exactly one rail is high.
  assign invalid = (a_t ~^ a_f) | (b_t ~^ b_f);

  always_comb begin
    t_raw = 1'b0;
    f_raw = 1'b0;
    case (op_e'(op_sel))
      OP_AND: begin
        t_raw = a_t & b_t;
        f_raw = a_f | b_f;
      end
      OP_OR: begin
        t_raw = a_t | b_t;
        f_raw = a_f & b_f;
      end
      OP_XOR: begin
        t_raw = (a_t & b_f) | (a_f & b_t);
        f_raw = (a_t & b_t) | (a_f & b_f);
      end
      OP_XNOR: begin
        t_raw = (a_t & b_t) | (a_f & b_f);
        f_raw = (a_t & b_f) | (a_f & b_t);
      end
      default: begin
        t_raw = 1'b0;
        f_raw = 1'b0;
      end
    endcase
  end

  // Invalid inputs collapse to the precharge value so no 11 can escape.
  assign o_t = t_raw & ~invalid;
  assign o_f = f_raw & ~invalid;

endmodule

// File: rtl/wddl_logic_stage.sv
// wddl_logic_stage: registered dual-rail logic stage with precharge/evaluate phasing.
//   Latency: 1 cycle from acceptance to out_valid; results then held until out_ready,
//   followed by PRE_CYCLES precharge cycles (peak one result per PRE_CYCLES+2 cycles).
//   Ports: clk, rst (sync, active-high); in_valid/in_ready + op_sel, a_t/a_f/b_t/b_f
//   operand handshake; out_valid/out_ready + o_t/o_f result handshake; code_err flag.
module wddl_logic_stage
  import wddl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] a_t,
  input  logic [WIDTH-1:0] a_f,
  input  logic [WIDTH-1:0] b_t,
  input  logic [WIDTH-1:0] b_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o_t,
  output logic [WIDTH-1:0] o_f,
  output logic             code_err
);

  localparam logic [PRE_CNT_W-1:0] PRE_LOAD = PRE_CNT_W'(PRE_CYCLES);
  localparam logic [PRE_CNT_W-1:0] CNT_ONE  = PRE_CNT_W'(1);

  state_e               state;
  state_e               state_nxt;
  logic [PRE_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     cell_t;
  logic [WIDTH-1:0]     cell_f;
  logic [WIDTH-1:0]     cell_inv;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    wddl_bit_cell u_cell (
      .op_sel  (op_sel),
      .a_t     (a_t[i]),
      .a_f     (a_f[i]),
      .b_t     (b_t[i]),
      .b_f     (b_f[i]),
      .o_t     (cell_t[i]),
      .o_f     (cell_f[i]),
      .invalid (cell_inv[i])
    );
  end

  // Handshake outputs come from the registered state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_PRE: begin
        if (cnt == CNT_ONE) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_PRE;
      end
      default: state_nxt = ST_PRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_PRE;
      cnt      <= PRE_LOAD;
      o_t      <= '0;
      o_f      <= '0;
      code_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_PRE: begin
          cnt <= cnt - CNT_ONE;
        end
        ST_WAIT: begin
          if (in_valid) begin
            o_t      <= cell_t;
            o_f      <= cell_f;
            code_err <= |cell_inv;
          end
        end
        ST_EVAL: begin
          // Leaving EVAL drops straight to the all-zero precharge spacer.
          if (out_ready) begin
            cnt      <= PRE_LOAD;
            o_t      <= '0;
            o_f      <= '0;
            code_err <= 1'b0;
          end
        end
        default: begin
          cnt <= PRE_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wddl_logic_stage.sv
// tb_wddl_logic_stage: directed vector bench for wddl_logic_stage.
//   Two instances: WIDTH=8/PRE_CYCLES=1 for function, PRE_CYCLES=3 for throughput.
//   Inputs driven and outputs sampled on the falling edge.
module tb_wddl_logic_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op_sel;
  logic [7:0] a_t, a_f, b_t, b_f;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] o_t, o_f;
  logic       code_err;

  logic       rst3;
  logic       in_valid3;
  logic       in_ready3;
  logic       out_valid3;
  logic       out_ready3;
  logic [7:0] o_t3, o_f3;
  logic       code_err3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wddl_logic_stage #(.WIDTH(8), .PRE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .o_t(o_t), .o_f(o_f), .code_err(code_err)
  );

  wddl_logic_stage #(.WIDTH(8), .PRE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
    .op_sel(op_sel), .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .o_t(o_t3), .o_f(o_f3), .code_err(code_err3)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a_t, a_f, b_t, b_f;
    logic [7:0] exp_t, exp_f;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic apply(input vec_t v);
    wait_ready();
    op_sel   = v.op;
    a_t      = v.a_t;
    a_f      = v.a_f;
    b_t      = v.b_t;
    b_f      = v.b_f;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[4];
    int nacc;
    int nout;

    vecs[0] = '{op:2'b00, a_t:8'hA5, a_f:8'h5A, b_t:8'h0F, b_f:8'hF0, exp_t:8'h05, exp_f:8'hFA, exp_err:1'b0};
    vecs[1] = '{op:2'b01, a_t:8'hA5, a_f:8'h5A, b_t:8'h0F, b_f:8'hF0, exp_t:8'hAF, exp_f:8'h50, exp_err:1'b0};
    vecs[2] = '{op:2'b10, a_t:8'h3C, a_f:8'hC3, b_t:8'hFF, b_f:8'h00, exp_t:8'hC3, exp_f:8'h3C, exp_err:1'b0};
    vecs[3] = '{op:2'b11, a_t:8'h3C, a_f:8'hC3, b_t:8'hFF, b_f:8'h00, exp_t:8'h3C, exp_f:8'hC3, exp_err:1'b0};
    vecs[4] = '{op:2'b00, a_t:8'hA5, a_f:8'h5E, b_t:8'h0F, b_f:8'hF0, exp_t:8'h01, exp_f:8'hFA, exp_err:1'b1};
    vecs[5] = '{op:2'b10, a_t:8'h3C, a_f:8'hC3, b_t:8'h7F, b_f:8'h00, exp_t:8'h43, exp_f:8'h3C, exp_err:1'b1};
    vecs[6] = '{op:2'b01, a_t:8'h00, a_f:8'hFF, b_t:8'h00, b_f:8'hFF, exp_t:8'h00, exp_f:8'hFF, exp_err:1'b0};
    vecs[7] = '{op:2'b11, a_t:8'hFF, a_f:8'h00, b_t:8'h00, b_f:8'hFF, exp_t:8'h00, exp_f:8'hFF, exp_err:1'b0};

    rst = 1'b1; rst3 = 1'b1;
    in_valid = 1'b0; in_valid3 = 1'b0;
    out_ready = 1'b0; out_ready3 = 1'b0;
    op_sel = 2'b00; a_t = '0; a_f = '0; b_t = '0; b_f = '0;

    // Reset and release: one precharge cycle, then WAIT.
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_o_t", {56'd0, o_t}, 64'd0);
    check("rst_o_f", {56'd0, o_f}, 64'd0);
    check("rst_code_err", {63'd0, code_err}, 64'd0);
    rst = 1'b0;
    check("pre_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("wait_in_ready_hold", {63'd0, in_ready}, 64'd1);
      check("wait_o_t", {56'd0, o_t}, 64'd0);
      check("wait_o_f", {56'd0, o_f}, 64'd0);
      @(negedge clk);
    end

    // Vector table: accept, check, hold with noisy inputs, release.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i]);
      check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("v%0d_o_t", i), {56'd0, o_t}, {56'd0, vecs[i].exp_t});
      check($sformatf("v%0d_o_f", i), {56'd0, o_f}, {56'd0, vecs[i].exp_f});
      check($sformatf("v%0d_code_err", i), {63'd0, code_err}, {63'd0, vecs[i].exp_err});
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        op_sel   = 2'($urandom);
        a_t      = 8'($urandom);
        a_f      = 8'($urandom);
        b_t      = 8'($urandom);
        b_f      = 8'($urandom);
        @(negedge clk);
        check($sformatf("v%0d_hold%0d_o_t", i, k), {56'd0, o_t}, {56'd0, vecs[i].exp_t});
        check($sformatf("v%0d_hold%0d_o_f", i, k), {56'd0, o_f}, {56'd0, vecs[i].exp_f});
        check($sformatf("v%0d_hold%0d_err", i, k), {63'd0, code_err}, {63'd0, vecs[i].exp_err});
        check($sformatf("v%0d_hold%0d_vld", i, k), {63'd0, out_valid}, 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("v%0d_rel_out_valid", i), {63'd0, out_valid}, 64'd0);
      check($sformatf("v%0d_rel_o_t", i), {56'd0, o_t}, 64'd0);
      check($sformatf("v%0d_rel_o_f", i), {56'd0, o_f}, 64'd0);
      check($sformatf("v%0d_rel_code_err", i), {63'd0, code_err}, 64'd0);
      check($sformatf("v%0d_rel_in_ready", i), {63'd0, in_ready}, 64'd0);
    end

    // Reset during EVAL discards the pending (erroneous) result.
    apply(vecs[4]);
    check("mid_err_before_rst", {63'd0, code_err}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_o_t", {56'd0, o_t}, 64'd0);
    check("mid_rst_o_f", {56'd0, o_f}, 64'd0);
    check("mid_rst_code_err", {63'd0, code_err}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("mid_rst_reload_wait", {63'd0, in_ready}, 64'd1);

    // PRE_CYCLES=3 instance: continuous in_valid and out_ready.
    op_sel = 2'b00; a_t = 8'hA5; a_f = 8'h5A; b_t = 8'h0F; b_f = 8'hF0;
    rst3 = 1'b0; in_valid3 = 1'b1; out_ready3 = 1'b1;
    nacc = 0;
    nout = 0;
    for (int cyc = 0; cyc < 40 && nacc < 4; cyc++) begin
      if (in_ready3 === 1'b1) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (out_valid3 === 1'b1) begin
        if (nout == 0) check("p3_o_t", {56'd0, o_t3}, 64'h05);
        nout++;
      end
      @(negedge clk);
    end
    check("p3_accept_count", 64'(nacc), 64'd4);
    if (nacc == 4) begin
      check("p3_first_accept", 64'(acc_cyc[0]), 64'd3);
      for (int j = 1; j < 4; j++)
        check($sformatf("p3_gap%0d", j), 64'(acc_cyc[j] - acc_cyc[j-1]), 64'd5);
    end
    check("p3_result_count", 64'(nout), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wddl_logic_stage.md
WDDL_LOGIC_STAGE -- requirements
Module: wddl_logic_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of dual-rail bit pairs per operand, legal range 1..64.
REQ-002 The block SHALL have parameter PRE_CYCLES, default 1: precharge cycles between evaluations, legal range 1..15.
REQ-003 The block SHALL use one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair presented.
REQ-007 in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 op_sel  input  2  00 AND, 01 OR, 10 XOR, 11 XNOR; sampled only on acceptance.
REQ-009 a_t, a_f, b_t, b_f  input  WIDTH each  dual-rail operands; true/false rail per bit.
REQ-010 out_valid  output  1  o_t/o_f hold an evaluated result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 o_t, o_f  output  WIDTH each  registered dual-rail result.
REQ-013 code_err  output  1  the accepted operands contained a non-codeword bit pair.

Function
REQ-014 The FSM SHALL have the states PRE, WAIT and EVAL.
REQ-015 In PRE, o_t and o_f SHALL be all-zero, in_ready and out_valid SHALL be 0, and a down-counter loaded with PRE_CYCLES SHALL decrement each cycle; PRE SHALL exit to WAIT on the edge where the counter is 1.
REQ-016 In WAIT, in_ready SHALL be 1, it SHALL be decoded from the registered state only, and the outputs SHALL remain all-zero.
REQ-017 On an edge with WAIT, in_valid=1 and in_ready=1, the block SHALL register the result, set out_valid=1 and enter EVAL; latency is 1 cycle.
REQ-018 In WAIT with in_valid=0, the block SHALL stay in WAIT indefinitely.
REQ-019 Per bit i, AND SHALL give o_t=a_t&b_t and o_f=a_f|b_f.
REQ-020 Per bit i, OR SHALL give o_t=a_t|b_t and o_f=a_f&b_f.
REQ-021 Per bit i, XOR SHALL give o_t=(a_t&b_f)|(a_f&b_t) and o_f=(a_t&b_t)|(a_f&b_f); XNOR SHALL give the XOR rails swapped.
REQ-022 A bit pair with both rails 1, or both rails 0, on either operand is invalid; that result bit SHALL be forced to 00, and code_err SHALL be 1 for the whole EVAL.
REQ-023 In EVAL, o_t, o_f, out_valid and code_err SHALL stay stable while out_ready=0.
REQ-024 On an edge in EVAL with out_ready=1, the block SHALL enter PRE with the counter loaded; on the next cycle the outputs SHALL be all-zero, out_valid=0 and code_err=0.
REQ-025 in_valid SHALL be ignored in PRE and EVAL, and input changes there SHALL have no effect.
REQ-026 Every evaluation SHALL be followed by at least PRE_CYCLES precharge cycles; peak throughput SHALL be one result per PRE_CYCLES+2 cycles.
REQ-027 In every valid result bit (code_err=0), exactly one of o_t/o_f SHALL be 1; no output bit SHALL ever be 11.

Reset
REQ-028 When rst=1 at an edge, the block SHALL enter PRE with the counter at PRE_CYCLES, o_t/o_f=0, out_valid=0, in_ready=0 and code_err=0, from any state including mid-EVAL.
REQ-029 rst SHALL take priority over every handshake event on the same edge; a pending result SHALL be discarded without a handshake.

Structure
REQ-030 Package wddl_pkg SHALL hold the op_sel encodings, the state enumeration and the PRE_CYCLES width constant (4 bits).
REQ-031 Sub-module wddl_bit_cell SHALL compute one bit's dual-rail result and invalid flag from op_sel; it SHALL be instantiated WIDTH times, and the invalid flags SHALL be OR-reduced into code_err.

Verification
REQ-032 WIDTH=8, PRE_CYCLES=1: release rst -> in_ready=0 for exactly 1 cycle, then 1; outputs 00 throughout.
REQ-033 AND with A=0xA5, B=0x0F encoded validly, accepted -> next cycle o_t=0x05, o_f=0xFA, out_valid=1, code_err=0.
REQ-034 XOR with A=0x3C, B=0xFF -> o_t=0xC3, o_f=0x3C; hold out_ready=0 for 5 cycles -> outputs stable; out_ready=1 -> next cycle all-zero, in_ready=0.
REQ-035 Bit 2 of A driven 11, others valid -> o_t[2]=o_f[2]=0, code_err=1 until the handshake completes.
REQ-036 PRE_CYCLES=3, back-to-back in_valid=1 -> accept edges exactly 5 cycles apart; in_valid asserted during PRE not accepted.
REQ-037 rst=1 during EVAL with out_ready=0 -> next cycle out_valid=0, outputs 00, state PRE, counter reloaded.
